// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module   : multdiv_pkg
// Brief    : Shared types and constants for the iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    // Controller-visible FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Operation latched at capture
    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // One result bit per cycle over a 32-bit operand
    localparam int ITER_DEFAULT = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Magnitude of a two's complement word; INT_MIN maps to 2^31 as unsigned
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module   : div_step
// Brief    : One restoring-division step on unsigned magnitudes. Shifts the
//            next dividend bit into the partial remainder and subtracts the
//            divisor when it fits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] divisor_i,
    input  logic        bit_i,
    output logic [31:0] rem_o,
    output logic        q_o
);

    logic [32:0] w_trial;
    logic [32:0] w_diff;

    // Trial subtraction; a clear borrow bit means the divisor fits
    always_comb begin
        w_trial = {rem_i, bit_i};
        w_diff  = w_trial - {1'b0, divisor_i};
        q_o     = ~w_diff[32];
        rem_o   = q_o ? w_diff[31:0] : w_trial[31:0];
    end

endmodule

`default_nettype wire

// File: rtl/multdiv_iter.sv
// ============================================================================
// Module   : multdiv_iter
// Brief    : Iterative signed 32-bit multiply / divide. Operands are captured
//            on a one-cycle start pulse, ITER iterations follow (one result
//            bit each, so ITER is expected to be 32), then result, exception
//            and a one-cycle ready pulse are registered.
//            Optional macro MULTDIV_EARLY_DONE_EN: trivially-zero multiplies
//            and divides by zero finish after one cycle instead of ITER.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam int             CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);

    state_e             state_q;
    op_e                op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        acc_q;      // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}
    logic [31:0]        opd_q;      // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic               sign_q;     // result must be negated
    logic               divzero_q;
    logic               divovf_q;   // INT_MIN / -1
    logic [31:0]        result_q;
    logic               exc_q;
    logic               rdy_q;
`ifdef MULTDIV_EARLY_DONE_EN
    logic               early_q;    // result known to be 0 at capture
`endif

    logic        w_start;
    op_e         w_op;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_acc;
    logic [31:0] w_div_rem;
    logic        w_div_q;
    logic [63:0] w_div_acc;
    logic [63:0] acc_d;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] result_d;
    logic        exc_d;
    logic        w_last;

    // Simultaneous MULT and DIV resolves to MULT
    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_op    = ctrl_MULT ? OP_MUL : OP_DIV;
    assign w_mag_a = abs32(data_operandA);
    assign w_mag_b = abs32(data_operandB);

    div_step u_div_step (
        .rem_i     (acc_q[63:32]),
        .divisor_i (opd_q),
        .bit_i     (acc_q[31]),
        .rem_o     (w_div_rem),
        .q_o       (w_div_q)
    );

    // One shift-add or restoring step, then the signed fix-up of the result
    always_comb begin
        w_mul_sum = {1'b0, acc_q[63:32]} + ({1'b0, opd_q} & {33{acc_q[0]}});
        w_mul_acc = {w_mul_sum, acc_q[31:1]};
        w_div_acc = {w_div_rem, acc_q[30:0], w_div_q};
        acc_d     = (op_q == OP_DIV) ? w_div_acc : w_mul_acc;

        w_prod    = sign_q ? (64'd0 - acc_d) : acc_d;
        w_quo     = sign_q ? (32'd0 - acc_d[31:0]) : acc_d[31:0];

        result_d  = 32'd0;
        exc_d     = 1'b0;
        if (op_q == OP_MUL) begin
            result_d = w_prod[31:0];
            // Product fits in 32 bits only if the top 33 bits are a sign extension
            exc_d    = ~((&w_prod[63:31]) | ~(|w_prod[63:31]));
        end else if (divzero_q) begin
            result_d = 32'd0;
            exc_d    = 1'b1;
        end else if (divovf_q) begin
            result_d = INT_MIN;
            exc_d    = 1'b1;
        end else begin
            result_d = w_quo;
            exc_d    = 1'b0;
        end
`ifdef MULTDIV_EARLY_DONE_EN
        if (early_q) begin
            result_d = 32'd0;
            exc_d    = (op_q == OP_DIV);
        end
`endif
    end

`ifdef MULTDIV_EARLY_DONE_EN
    assign w_last = (cnt_q == C_LAST) || early_q;
`else
    assign w_last = (cnt_q == C_LAST);
`endif

    // Control FSM and datapath registers; a start in any state (re)captures
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            acc_q     <= 64'd0;
            opd_q     <= 32'd0;
            sign_q    <= 1'b0;
            divzero_q <= 1'b0;
            divovf_q  <= 1'b0;
            result_q  <= 32'd0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
`ifdef MULTDIV_EARLY_DONE_EN
            early_q   <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (w_start) begin
                state_q   <= ST_RUN;
                op_q      <= w_op;
                cnt_q     <= '0;
                acc_q     <= {32'd0, (w_op == OP_MUL) ? w_mag_b : w_mag_a};
                opd_q     <= (w_op == OP_MUL) ? w_mag_a : w_mag_b;
                sign_q    <= data_operandA[31] ^ data_operandB[31];
                divzero_q <= (data_operandB == 32'd0);
                divovf_q  <= (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
                result_q  <= 32'd0;
                exc_q     <= 1'b0;
`ifdef MULTDIV_EARLY_DONE_EN
                early_q   <= (w_op == OP_MUL)
                             ? ((data_operandA == 32'd0) || (data_operandB == 32'd0))
                             : (data_operandB == 32'd0);
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_RUN: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (w_last) begin
                            result_q <= result_d;
                            exc_q    <= exc_d;
                            rdy_q    <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_iter.sv
// ============================================================================
// Module   : tb_multdiv_iter
// Brief    : Self-checking bench for multdiv_iter with a behavioural model
//            built on 64-bit signed arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_iter;

    localparam int ITER = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    multdiv_iter #(.ITER(ITER)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    // Reference: signed arithmetic at full width, then the exception rules
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit is_mul,
                                  output logic [31:0] res, output logic exc, output int lat);
        longint p;
        longint lo;
        int     q;
        if (is_mul) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            lo  = longint'($signed(res));
            exc = (p != lo);
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            q   = $signed(a) / $signed(b);
            res = q;
            exc = 1'b0;
        end
        lat = ITER;
`ifdef MULTDIV_EARLY_DONE_EN
        if (is_mul ? (a == 32'd0 || b == 32'd0) : (b == 32'd0))
            lat = 1;
`endif
    endfunction

    // Call at a negedge: presents a one-cycle start pulse captured on the next posedge
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input bit mul, input bit div);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Counts negedges after the capture edge until RDY; lat = -1 on timeout
    task automatic wait_rdy(output int lat, output logic [31:0] res, output logic exc);
        lat = -1;
        res = 32'd0;
        exc = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                lat = k;
                res = data_result;
                exc = data_exception;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'd0; data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        checks++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b, want all 0", data_result, data_exception, data_resultRDY);
        end
        // Reset wins over a simultaneous start
        ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd3;
        @(negedge clock);
        ctrl_MULT = 1'b0; reset = 1'b0;
        seen = 0;
        repeat (ITER + 5) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_priority: got %0d RDY cycles, want 0", seen);
        end
    endtask

    task automatic test_mult_basic();
        logic [31:0] er, r; logic ee, e; int el, l;
        model(32'd7, 32'hFFFF_FFFD, 1'b1, er, ee, el);
        @(negedge clock);
        drive_start(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        wait_rdy(l, r, e);
        checks++;
        if (l !== el) begin failures++; $display("FAIL mult_latency: got %0d, want %0d", l, el); end
        checks++;
        if (r !== er || r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_result: got %h, want %h", r, er); end
        checks++;
        if (e !== ee) begin failures++; $display("FAIL mult_exc: got %b, want %b", e, ee); end
        // RDY is a single-cycle pulse; result holds afterwards
        @(negedge clock);
        checks++;
        if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL rdy_pulse_width: got %b, want 0", data_resultRDY); end
        repeat (3) @(negedge clock);
        checks++;
        if (data_result !== er || data_exception !== ee) begin
            failures++;
            $display("FAIL result_hold: got %h/%b, want %h/%b", data_result, data_exception, er, ee);
        end
    endtask

    task automatic test_mult_overflow();
        logic [31:0] r; logic e; int l;
        @(negedge clock);
        drive_start(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        wait_rdy(l, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b1) begin
            failures++;
            $display("FAIL mult_overflow: got %h/%b, want 00000000/1", r, e);
        end
    endtask

    task automatic test_div_basic();
        logic [31:0] r; logic e; int l;
        @(negedge clock);
        drive_start(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
        wait_rdy(l, r, e);
        checks++;
        if (r !== 32'hFFFF_FFF2 || e !== 1'b0 || l != ITER) begin
            failures++;
            $display("FAIL div_basic: got %h/%b lat %0d, want fffffff2/0 lat %0d", r, e, l, ITER);
        end
    endtask

    task automatic test_div_special();
        logic [31:0] r, er; logic e, ee; int l, el;
        model(32'd5, 32'd0, 1'b0, er, ee, el);
        @(negedge clock);
        drive_start(32'd5, 32'd0, 1'b0, 1'b1);
        wait_rdy(l, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b1 || l != el) begin
            failures++;
            $display("FAIL div_by_zero: got %h/%b lat %0d, want 0/1 lat %0d", r, e, l, el);
        end
        @(negedge clock);
        drive_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_rdy(l, r, e);
        checks++;
        if (r !== 32'h8000_0000 || e !== 1'b1) begin
            failures++;
            $display("FAIL div_int_min: got %h/%b, want 80000000/1", r, e);
        end
    endtask

    task automatic test_both_ctrl();
        logic [31:0] r; logic e; int l;
        @(negedge clock);
        drive_start(32'd12, 32'd4, 1'b1, 1'b1);
        wait_rdy(l, r, e);
        checks++;
        if (r !== 32'd48 || e !== 1'b0) begin
            failures++;
            $display("FAIL both_ctrl_is_mult: got %h/%b, want 00000030/0", r, e);
        end
    endtask

    task automatic test_restart();
        logic [31:0] r; logic e; int l, seen;
        @(negedge clock);
        drive_start(32'd3, 32'd4, 1'b1, 1'b0);
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) seen++;
        end
        drive_start(32'd100, 32'd10, 1'b0, 1'b1);
        wait_rdy(l, r, e);
        checks++;
        if (seen != 0) begin failures++; $display("FAIL restart_no_rdy: got %0d RDY cycles, want 0", seen); end
        checks++;
        if (r !== 32'd10 || e !== 1'b0 || l != ITER) begin
            failures++;
            $display("FAIL restart_result: got %h/%b lat %0d, want 0000000a/0 lat %0d", r, e, l, ITER);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; logic e; int l, seen;
        @(negedge clock);
        drive_start(32'd9, 32'd9, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            failures++;
            $display("FAIL reset_mid_op: got res=%h exc=%b rdy=%b, want all 0", data_result, data_exception, data_resultRDY);
        end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (ITER + 5) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL reset_abort_rdy: got %0d RDY cycles, want 0", seen); end
        drive_start(32'd2, 32'd2, 1'b1, 1'b0);
        wait_rdy(l, r, e);
        checks++;
        if (r !== 32'd4 || e !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_mult: got %h/%b, want 00000004/0", r, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, er; logic e, ee; int l, el;
        @(negedge clock);
        drive_start(32'd1000, 32'hFFFF_FFF6, 1'b0, 1'b1);
        wait_rdy(l, r, e);
        // Next start shares the RDY cycle
        model(32'hFFFF_FFF9, 32'hFFFF_FFF9, 1'b1, er, ee, el);
        drive_start(32'hFFFF_FFF9, 32'hFFFF_FFF9, 1'b1, 1'b0);
        checks++;
        if (r !== 32'hFFFF_FF9C || e !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got %h/%b, want ffffff9c/0", r, e);
        end
        wait_rdy(l, r, e);
        checks++;
        if (r !== er || e !== ee || l != el) begin
            failures++;
            $display("FAIL b2b_second: got %h/%b lat %0d, want %h/%b lat %0d", r, e, l, er, ee, el);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, er; logic e, ee; int l, el; bit mul;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = $urandom_range(0, 200) - 100;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(0, 200) - 100;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            mul = $urandom_range(0, 1);
            model(a, b, mul, er, ee, el);
            @(negedge clock);
            drive_start(a, b, mul, !mul);
            wait_rdy(l, r, e);
            checks++;
            if (r !== er || e !== ee || l != el) begin
                failures++;
                $display("FAIL random_%s a=%h b=%h: got %h/%b lat %0d, want %h/%b lat %0d",
                         mul ? "mul" : "div", a, b, r, e, l, er, ee, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_mult_overflow();
        test_div_basic();
        test_div_special();
        test_both_ctrl();
        test_restart();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
